// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 16x-oversampled UART transmit serializer
// 5-8 data bits, optional/stick parity, 1/1.5/2 stop bits, break override.
module uart_tx_serializer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic       TXSTART,
  input  logic [7:0] DIN,
  input  logic [1:0] WLS,
  input  logic       STB,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       BC,
  output logic       SOUT,
  output logic       TXBUSY,
  output logic       TXFINISHED
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic [1:0] wls_q;
  logic       stb_q;
  logic       pen_q;
  logic       par_q;
  logic       sout_q;

  logic [7:0] din_mask;
  logic       din_xor;
  logic       par_next;
  logic       tick_last;
  logic       data_last;
  logic       stop_last;

  // Parity is resolved at accept time from the word-length-masked data,
  // since the shift register no longer holds the whole word later on.
  always_comb begin
    case (WLS)
      2'b00:   din_mask = {3'b000, DIN[4:0]};
      2'b01:   din_mask = {2'b00, DIN[5:0]};
      2'b10:   din_mask = {1'b0, DIN[6:0]};
      default: din_mask = DIN;
    endcase
    din_xor  = ^din_mask;
    par_next = SP ? ~EPS : (EPS ? din_xor : ~din_xor);
  end

  assign tick_last = (tick_cnt == 4'd15);
  assign data_last = (bit_cnt == {1'b1, wls_q});

  // STOP spans one or two 16-tick periods (bit_cnt 0/1); 1.5 stop bits ends
  // halfway through the second period.
  always_comb begin
    stop_last = 1'b0;
    if (!stb_q) begin
      stop_last = tick_last && (bit_cnt == 3'd0);
    end else if (wls_q == 2'b00) begin
      stop_last = (bit_cnt == 3'd1) && (tick_cnt == 4'd7);
    end else begin
      stop_last = (bit_cnt == 3'd1) && tick_last;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      tick_cnt   <= 4'd0;
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'd0;
      wls_q      <= 2'd0;
      stb_q      <= 1'b0;
      pen_q      <= 1'b0;
      par_q      <= 1'b0;
      sout_q     <= 1'b1;
      TXBUSY     <= 1'b0;
      TXFINISHED <= 1'b0;
    end else begin
      TXFINISHED <= 1'b0;
      case (state)
        IDLE: begin
          if (TXSTART) begin
            state     <= START;
            shift_reg <= DIN;
            wls_q     <= WLS;
            stb_q     <= STB;
            pen_q     <= PEN;
            par_q     <= par_next;
            tick_cnt  <= 4'd0;
            bit_cnt   <= 3'd0;
            TXBUSY    <= 1'b1;
            sout_q    <= 1'b0;
          end
        end
        default: begin
          if (CE) begin
            tick_cnt <= tick_cnt + 4'd1;
            case (state)
              START: begin
                if (tick_last) begin
                  state  <= DATA;
                  sout_q <= shift_reg[0];
                end
              end
              DATA: begin
                if (tick_last) begin
                  if (data_last) begin
                    bit_cnt <= 3'd0;
                    if (pen_q) begin
                      state  <= PARITY;
                      sout_q <= par_q;
                    end else begin
                      state  <= STOP;
                      sout_q <= 1'b1;
                    end
                  end else begin
                    bit_cnt   <= bit_cnt + 3'd1;
                    shift_reg <= {1'b0, shift_reg[7:1]};
                    sout_q    <= shift_reg[1];
                  end
                end
              end
              PARITY: begin
                if (tick_last) begin
                  state  <= STOP;
                  sout_q <= 1'b1;
                end
              end
              STOP: begin
                if (tick_last) begin
                  bit_cnt <= bit_cnt + 3'd1;
                end
                if (stop_last) begin
                  state      <= IDLE;
                  tick_cnt   <= 4'd0;
                  bit_cnt    <= 3'd0;
                  TXBUSY     <= 1'b0;
                  TXFINISHED <= 1'b1;
                  sout_q     <= 1'b1;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // Break overrides the line directly so it takes effect without waiting a cycle.
  assign SOUT = sout_q & ~BC;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CE = 1'b0;
  logic       TXSTART = 1'b0;
  logic [7:0] DIN = 8'd0;
  logic [1:0] WLS = 2'd0;
  logic       STB = 1'b0;
  logic       PEN = 1'b0;
  logic       EPS = 1'b0;
  logic       SP = 1'b0;
  logic       BC = 1'b0;
  logic       SOUT;
  logic       TXBUSY;
  logic       TXFINISHED;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_din;
  int         m_w;
  int         m_len;
  logic       m_pen;
  logic       m_par;
  int         bc_lo = 1;
  int         bc_hi = 0;

  uart_tx_serializer dut (
    .CLK(CLK), .RST(RST), .CE(CE), .TXSTART(TXSTART), .DIN(DIN), .WLS(WLS),
    .STB(STB), .PEN(PEN), .EPS(EPS), .SP(SP), .BC(BC),
    .SOUT(SOUT), .TXBUSY(TXBUSY), .TXFINISHED(TXFINISHED)
  );

  always #5 CLK = ~CLK;

  function automatic logic model_sout(input int t);
    int slot;
    slot = t / 16;
    if (slot == 0) return 1'b0;
    if (slot <= m_w) return m_din[slot-1];
    if (m_pen && slot == m_w + 1) return m_par;
    return 1'b1;
  endfunction

  task automatic setup(input logic [7:0] din, input logic [1:0] wls, input logic stb,
                       input logic pen, input logic eps, input logic sp, input logic par);
    DIN = din; WLS = wls; STB = stb; PEN = pen; EPS = eps; SP = sp;
    m_din = din; m_w = 5 + int'(wls); m_pen = pen; m_par = par;
    m_len = 16 * (1 + m_w + int'(pen)) + (stb ? ((wls == 2'b00) ? 24 : 32) : 16);
  endtask

  task automatic accept(input logic ce);
    CE = ce; TXSTART = 1'b1;
    @(posedge CLK);
    #1 TXSTART = 1'b0;
  endtask

  // poke: 0 = TXSTART low, 1 = sporadic pulses, 2 = held high through the frame
  task automatic run_frame(input int cep, input int poke, output int errs, output int cyc);
    int t;
    t = 0; errs = 0; cyc = 0;
    BC = (bc_lo <= 0) && (0 <= bc_hi);
    while (t < m_len && cyc < 5000) begin
      @(negedge CLK);
      if (SOUT !== (BC ? 1'b0 : model_sout(t))) errs++;
      if (TXBUSY !== 1'b1 || TXFINISHED !== 1'b0) errs++;
      CE = ((cyc + 1) % cep) == 0;
      DIN = 8'($urandom); WLS = 2'($urandom); STB = 1'($urandom);
      PEN = 1'($urandom); EPS = 1'($urandom); SP = 1'($urandom);
      if (poke == 1) TXSTART = (cyc % 37) == 5;
      else if (poke == 2) TXSTART = 1'b1;
      @(posedge CLK);
      if (CE) t++;
      cyc++;
      #1;
      if (poke != 2) TXSTART = 1'b0;
      BC = (bc_lo <= cyc) && (cyc <= bc_hi);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; TXSTART = 1'b1; CE = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if (SOUT !== 1'b1) begin n_errors++; $display("FAIL reset_sout: got %b expected 1", SOUT); end
    n_checks++; if (TXBUSY !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", TXBUSY); end
    n_checks++; if (TXFINISHED !== 1'b0) begin n_errors++; $display("FAIL reset_fin: got %b expected 0", TXFINISHED); end
    @(negedge CLK); RST = 1'b0; TXSTART = 1'b0;
    @(posedge CLK); #1;
    n_checks++; if (TXBUSY !== 1'b0) begin n_errors++; $display("FAIL idle_busy: got %b expected 0", TXBUSY); end
  endtask

  task automatic test_8n1();
    int errs, cyc;
    setup(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    accept(1'b1);
    n_checks++; if (TXBUSY !== 1'b1 || SOUT !== 1'b0) begin n_errors++; $display("FAIL 8n1_accept: got busy %b sout %b expected 1 0", TXBUSY, SOUT); end
    run_frame(1, 0, errs, cyc);
    n_checks++; if (errs !== 0) begin n_errors++; $display("FAIL 8n1_wave: got %0d bad cycles expected 0", errs); end
    n_checks++; if (cyc !== 160) begin n_errors++; $display("FAIL 8n1_len: got %0d expected 160", cyc); end
    n_checks++; if (TXFINISHED !== 1'b1 || TXBUSY !== 1'b0 || SOUT !== 1'b1) begin n_errors++; $display("FAIL 8n1_end: got fin %b busy %b sout %b expected 1 0 1", TXFINISHED, TXBUSY, SOUT); end
    @(posedge CLK); #1;
    n_checks++; if (TXFINISHED !== 1'b0) begin n_errors++; $display("FAIL 8n1_pulse: got %b expected 0", TXFINISHED); end
  endtask

  task automatic test_word_lengths();
    int errs, cyc;
    setup(8'hFF, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    accept(1'b1);
    run_frame(1, 0, errs, cyc);
    n_checks++; if (errs !== 0) begin n_errors++; $display("FAIL 5e15_wave: got %0d bad cycles expected 0", errs); end
    n_checks++; if (cyc !== 136) begin n_errors++; $display("FAIL 5e15_len: got %0d expected 136", cyc); end
    setup(8'h7F, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    accept(1'b1);
    run_frame(1, 0, errs, cyc);
    n_checks++; if (errs !== 0 || cyc !== 160) begin n_errors++; $display("FAIL stick_eps1: got %0d bad cycles len %0d expected 0 160", errs, cyc); end
    setup(8'h7F, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    accept(1'b1);
    run_frame(1, 0, errs, cyc);
    n_checks++; if (errs !== 0 || cyc !== 160) begin n_errors++; $display("FAIL stick_eps0: got %0d bad cycles len %0d expected 0 160", errs, cyc); end
    setup(8'h2B, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    accept(1'b1);
    run_frame(1, 0, errs, cyc);
    n_checks++; if (errs !== 0 || cyc !== 160) begin n_errors++; $display("FAIL 6o2: got %0d bad cycles len %0d expected 0 160", errs, cyc); end
    setup(8'hA7, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    accept(1'b1);
    run_frame(1, 0, errs, cyc);
    n_checks++; if (errs !== 0 || cyc !== 192) begin n_errors++; $display("FAIL 8e2: got %0d bad cycles len %0d expected 0 192", errs, cyc); end
  endtask

  task automatic test_slow_ce();
    int errs, cyc, fins, busy;
    setup(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    accept(1'b0);
    n_checks++; if (TXBUSY !== 1'b1) begin n_errors++; $display("FAIL slow_accept: got %b expected 1", TXBUSY); end
    run_frame(4, 1, errs, cyc);
    n_checks++; if (errs !== 0) begin n_errors++; $display("FAIL slow_wave: got %0d bad cycles expected 0", errs); end
    n_checks++; if (cyc !== 640) begin n_errors++; $display("FAIL slow_len: got %0d expected 640", cyc); end
    n_checks++; if (TXFINISHED !== 1'b1) begin n_errors++; $display("FAIL slow_fin: got %b expected 1", TXFINISHED); end
    fins = 0; busy = 0;
    repeat (20) begin
      @(posedge CLK); #1;
      fins += int'(TXFINISHED); busy += int'(TXBUSY);
    end
    n_checks++; if (fins !== 0 || busy !== 0) begin n_errors++; $display("FAIL slow_after: got fin %0d busy %0d expected 0 0", fins, busy); end
  endtask

  task automatic test_break();
    int errs, cyc;
    BC = 1'b1; #1;
    n_checks++; if (SOUT !== 1'b0 || TXBUSY !== 1'b0) begin n_errors++; $display("FAIL brk_idle: got sout %b busy %b expected 0 0", SOUT, TXBUSY); end
    BC = 1'b0; #1;
    n_checks++; if (SOUT !== 1'b1) begin n_errors++; $display("FAIL brk_release: got %b expected 1", SOUT); end
    bc_lo = 20; bc_hi = 60;
    setup(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    accept(1'b1);
    run_frame(1, 0, errs, cyc);
    bc_lo = 1; bc_hi = 0; BC = 1'b0;
    n_checks++; if (errs !== 0) begin n_errors++; $display("FAIL brk_wave: got %0d bad cycles expected 0", errs); end
    n_checks++; if (cyc !== 160 || TXFINISHED !== 1'b1) begin n_errors++; $display("FAIL brk_end: got len %0d fin %b expected 160 1", cyc, TXFINISHED); end
  endtask

  task automatic test_reset_midframe();
    int errs, cyc;
    setup(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    accept(1'b1);
    repeat (50) @(posedge CLK);
    #1;
    n_checks++; if (SOUT !== 1'b0 || TXBUSY !== 1'b1) begin n_errors++; $display("FAIL mid_pre: got sout %b busy %b expected 0 1", SOUT, TXBUSY); end
    RST = 1'b1; #1;
    n_checks++; if (SOUT !== 1'b1 || TXBUSY !== 1'b0) begin n_errors++; $display("FAIL mid_rst: got sout %b busy %b expected 1 0", SOUT, TXBUSY); end
    @(negedge CLK); RST = 1'b0;
    setup(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    accept(1'b1);
    n_checks++; if (TXBUSY !== 1'b1) begin n_errors++; $display("FAIL mid_restart: got %b expected 1", TXBUSY); end
    run_frame(1, 0, errs, cyc);
    n_checks++; if (errs !== 0 || cyc !== 160) begin n_errors++; $display("FAIL mid_frame: got %0d bad cycles len %0d expected 0 160", errs, cyc); end
  endtask

  task automatic test_back_to_back();
    int errs, cyc;
    setup(8'h96, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    accept(1'b1);
    run_frame(1, 2, errs, cyc);
    n_checks++; if (errs !== 0 || cyc !== 160) begin n_errors++; $display("FAIL b2b_first: got %0d bad cycles len %0d expected 0 160", errs, cyc); end
    n_checks++; if (TXFINISHED !== 1'b1 || TXBUSY !== 1'b0) begin n_errors++; $display("FAIL b2b_gap: got fin %b busy %b expected 1 0", TXFINISHED, TXBUSY); end
    setup(8'h0F, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge CLK);
    #1 TXSTART = 1'b0;
    n_checks++; if (TXBUSY !== 1'b1 || SOUT !== 1'b0) begin n_errors++; $display("FAIL b2b_accept: got busy %b sout %b expected 1 0", TXBUSY, SOUT); end
    run_frame(1, 0, errs, cyc);
    n_checks++; if (errs !== 0 || cyc !== 144) begin n_errors++; $display("FAIL b2b_second: got %0d bad cycles len %0d expected 0 144", errs, cyc); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_8n1();
    test_word_lengths();
    test_slow_ce();
    test_break();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have port CLK  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port CE  in  1  16x oversample tick from the baud generator; all bit timing advances only on CLK edges with CE=1.
REQ-004 SHALL have port TXSTART  in  1  frame request, sampled only in IDLE.
REQ-005 SHALL have port DIN  in  8  frame data, LSB transmitted first.
REQ-006 SHALL have port WLS  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
REQ-007 SHALL have port STB  in  1  stop bits: 0=1; 1=1.5 if WLS=00, else 2.
REQ-008 SHALL have ports PEN, EPS, SP  in  1 each  parity enable, even-parity select, stick parity.
REQ-009 SHALL have port BC  in  1  break control.
REQ-010 SHALL have port SOUT  out  1  serial line, idle high.
REQ-011 SHALL have port TXBUSY  out  1  high from accept edge until frame end.
REQ-012 SHALL have port TXFINISHED  out  1  one-CLK pulse at frame end.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP; SOUT, TXBUSY, TXFINISHED registered.
REQ-014 SHALL, on a CLK edge in IDLE with TXSTART=1 (CE irrelevant), latch DIN, WLS, STB, PEN, EPS, SP, clear 4-bit tick counter and bit counter, enter START, set TXBUSY=1, SOUT=0.
REQ-015 SHALL drive SOUT per state: START=0, DATA=current shift bit, PARITY=parity bit, STOP=1, IDLE=1.
REQ-016 SHALL hold START, each DATA bit and PARITY for exactly 16 CE ticks; STOP for 16, 24 or 32 ticks per latched STB/WLS.
REQ-017 SHALL transition START->DATA; DATA->DATA until latched word length reached; then PARITY if latched PEN=1, else STOP; STOP->IDLE.
REQ-018 SHALL compute parity over only the latched word-length bits: SP=1 -> parity=~EPS; SP=0, EPS=1 -> XOR of bits; SP=0, EPS=0 -> inverted XOR.
REQ-019 SHALL, on the edge consuming the final stop tick, enter IDLE, set TXBUSY=0, pulse TXFINISHED=1 for exactly one CLK.
REQ-020 SHALL spend at least one CLK in IDLE between frames; TXSTART high on the finishing edge is accepted on the next edge.
REQ-021 SHALL ignore TXSTART and input changes while TXBUSY=1.
REQ-022 SHALL freeze all state and counters while CE=0 (except the IDLE accept of REQ-014).
REQ-023 SHALL force SOUT=0 whenever BC=1, in any state, without affecting state, counters, TXBUSY or TXFINISHED timing.
REQ-024 SHALL make frame length 16*(1+W+P)+S CE ticks, W=5..8, P=PEN, S=16/24/32.

Reset
REQ-025 SHALL, on RST=1 at any time, including mid-frame, immediately set state=IDLE, SOUT=1, TXBUSY=0, TXFINISHED=0, counters and shift register 0.
REQ-026 SHALL accept a new TXSTART on the first CLK edge after RST deasserts.

Verification
REQ-027 CE=1 constantly, WLS=11, PEN=0, STB=0, DIN=0x55, TXSTART pulse -> SOUT 0,1,0,1,0,1,0,1,0,1, 16 CLK each; TXFINISHED at edge 160 after accept.
REQ-028 WLS=00, PEN=1, EPS=1, SP=0, STB=1, DIN=0xFF -> data 11111, parity bit 1, stop 24 ticks; frame 136 CLK.
REQ-029 WLS=10, PEN=1, SP=1, EPS=1, DIN=0x7F -> parity bit 0; repeat with EPS=0 -> parity bit 1.
REQ-030 CE high every 4th CLK, 8N1 -> each bit 64 CLK, frame 640 CLK; TXSTART pulses during frame ignored, TXFINISHED exactly once.
REQ-031 BC=1 for CLK 20-60 of an 8N1 frame -> SOUT=0 there, frame otherwise unchanged, TXFINISHED still at edge 160.
REQ-032 RST asserted at CLK 50 of a frame -> SOUT=1, TXBUSY=0 same cycle; new TXSTART after release starts a full frame.
